// File: rtl/print_sched_pkg.sv
// Shared types and helpers for the print scheduler: FSM states, op kinds,
// field widths and the origin packing used on print's orig port.
package print_pkg;

    localparam int ORIG_W = 15;
    localparam int CARD_W = 6;

    typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} sched_state_t;
    typedef enum logic {INIT, CARD} op_kind_t;

    function automatic logic [ORIG_W-1:0] pack_orig(input logic [7:0] x, input logic [6:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/print_sched_rr_arb2.sv
// Two-requester round-robin arbiter; index 0 is the player, index 1 the dealer.
// The pointer only moves when the owner pulses advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;  // 0 favours requester 0

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~ptr;
    end

    assign gnt[0] = req[0] & (~req[1] | ~ptr);
    assign gnt[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/print_sched.sv
// Serialises screen-clear and player/dealer card draws onto print's single
// write/waitrequest port, placing each card from a per-hand slot counter.
module print_sched
    import print_pkg::*;
#(
    parameter int X0        = 4,
    parameter int X_STEP    = 20,
    parameter int P_Y       = 80,
    parameter int D_Y       = 10,
    parameter int MAX_SLOTS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              p_req,
    input  logic [CARD_W-1:0] p_card,
    output logic              p_ack,
    input  logic              d_req,
    input  logic [CARD_W-1:0] d_card,
    output logic              d_ack,
    output logic              busy,
    output logic              overflow,
    output logic              pr_write,
    output logic              pr_init,
    output logic [CARD_W-1:0] pr_card,
    output logic [ORIG_W-1:0] pr_orig,
    input  logic              pr_waitrequest
);

    sched_state_t state;
    op_kind_t     kind;
    logic         side_d;
    logic         init_pend;
    logic [2:0]   p_slot, d_slot;
    logic         ovf_ack_p, ovf_ack_d;

    logic       arb_en;
    logic [1:0] req_m, gnt;
    logic       sel_d, full;
    logic [2:0] sel_slot;
    logic [7:0] x_calc;
    logic [6:0] y_calc;

    // A requester still sees its overflow ack this cycle, so it must not be re-granted.
    assign req_m  = {d_req & ~ovf_ack_d, p_req & ~ovf_ack_p};
    assign arb_en = (state == IDLE) && !init_pend;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_en ? req_m : 2'b00),
        .advance (arb_en && (&req_m)),
        .gnt     (gnt)
    );

    assign sel_d    = gnt[1];
    assign sel_slot = sel_d ? d_slot : p_slot;
    assign full     = (sel_slot == 3'(MAX_SLOTS));
    assign x_calc   = 8'(X0) + 8'(sel_slot) * 8'(X_STEP);
    assign y_calc   = sel_d ? 7'(D_Y) : 7'(P_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            kind      <= INIT;
            side_d    <= 1'b0;
            init_pend <= 1'b1;
            p_slot    <= '0;
            d_slot    <= '0;
            overflow  <= 1'b0;
            ovf_ack_p <= 1'b0;
            ovf_ack_d <= 1'b0;
            pr_card   <= '0;
            pr_orig   <= '0;
        end else begin
            ovf_ack_p <= 1'b0;
            ovf_ack_d <= 1'b0;
            if (clr_req)
                init_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (init_pend) begin
                        // A clear arriving on this edge is covered by the init being started.
                        state     <= ISSUE;
                        kind      <= INIT;
                        init_pend <= 1'b0;
                        p_slot    <= '0;
                        d_slot    <= '0;
                        overflow  <= 1'b0;
                    end else if (|gnt) begin
                        if (full) begin
                            overflow  <= 1'b1;
                            ovf_ack_p <= ~sel_d;
                            ovf_ack_d <= sel_d;
                        end else begin
                            state   <= ISSUE;
                            kind    <= CARD;
                            side_d  <= sel_d;
                            pr_card <= sel_d ? d_card : p_card;
                            pr_orig <= pack_orig(x_calc, y_calc);
                            if (sel_d)
                                d_slot <= d_slot + 3'd1;
                            else
                                p_slot <= p_slot + 3'd1;
                        end
                    end
                end
                ISSUE: state <= GUARD;
                // print raises waitrequest one cycle late, so it is not looked at here
                GUARD: state <= WAIT;
                WAIT: if (!pr_waitrequest) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign pr_write = (state == ISSUE);
    assign pr_init  = pr_write && (kind == INIT);
    assign p_ack    = (pr_write && (kind == CARD) && !side_d) || ovf_ack_p;
    assign d_ack    = (pr_write && (kind == CARD) &&  side_d) || ovf_ack_d;
    assign busy     = !rst && ((state != IDLE) || init_pend);

endmodule

// File: tb/tb_print_sched.sv
// Self-checking bench for print_sched: a hand/pointer reference model predicts
// acks, grant order and card origins for random and directed request sequences.
module tb_print_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_req = 1'b0;
    logic        p_req = 1'b0, d_req = 1'b0;
    logic [5:0]  p_card = '0, d_card = '0;
    logic        p_ack, d_ack, busy, overflow, pr_write, pr_init;
    logic [5:0]  pr_card;
    logic [14:0] pr_orig;
    logic        pr_waitrequest = 1'b0;

    int checks = 0, failures = 0;
    int wlen = 5, wcnt = 0;

    // reference model state
    int pcnt = 0, dcnt = 0;
    bit ptr = 1'b0;
    bit movf = 1'b0;

    print_sched dut (
        .clk(clk), .rst(rst), .clr_req(clr_req),
        .p_req(p_req), .p_card(p_card), .p_ack(p_ack),
        .d_req(d_req), .d_card(d_card), .d_ack(d_ack),
        .busy(busy), .overflow(overflow),
        .pr_write(pr_write), .pr_init(pr_init), .pr_card(pr_card), .pr_orig(pr_orig),
        .pr_waitrequest(pr_waitrequest)
    );

    always #5 clk = ~clk;

    // print model: waitrequest high for wlen cycles after a write is seen
    always @(negedge clk) begin
        if (pr_write) wcnt = wlen;
        else if (wcnt > 0) wcnt--;
        pr_waitrequest = (wcnt > 0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] exp_orig(input int side, input int slot);
        int x, y;
        x = 4 + slot * 20;
        y = (side != 0) ? 10 : 80;
        return {x[7:0], y[6:0]};
    endfunction

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    // one isolated request; model predicts a write or an overflow ack
    task automatic do_req(input int side, input logic [5:0] card);
        int  slot;
        bit  ok = 1'b0;
        slot = (side != 0) ? dcnt : pcnt;
        if (side != 0) begin d_req = 1'b1; d_card = card; end
        else           begin p_req = 1'b1; p_card = card; end
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((side != 0) ? d_ack : p_ack) begin ok = 1'b1; break; end
        end
        chk("ack_seen", 32'(ok), 32'd1);
        p_req = 1'b0;
        d_req = 1'b0;
        if (ok) begin
            if (slot < 7) begin
                chk("card_write", 32'(pr_write), 32'd1);
                chk("card_noinit", 32'(pr_init), 32'd0);
                chk("card_code", 32'(pr_card), 32'(card));
                chk("card_orig", 32'(pr_orig), 32'(exp_orig(side, slot)));
                if (side != 0) dcnt++; else pcnt++;
            end else begin
                movf = 1'b1;
                chk("ovf_nowrite", 32'(pr_write), 32'd0);
            end
            chk("ovf_flag", 32'(overflow), 32'(movf));
        end
        wait_idle();
    endtask

    // wait for the next write; it must be an init with no dealer ack before it
    task automatic expect_init_first();
        bit got = 1'b0, early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (d_ack || p_ack) early = 1'b1;
            if (pr_write) begin got = 1'b1; break; end
        end
        chk("init_seen", 32'(got), 32'd1);
        chk("init_flag", 32'(pr_init), 32'd1);
        chk("ack_before_init", 32'(early), 32'd0);
        pcnt = 0; dcnt = 0; movf = 1'b0;
    endtask

    initial begin
        bit ok;
        int grants, side;
        logic [5:0] c;

        // reset state
        repeat (3) tick();
        chk("rst_outputs", 32'({p_ack, d_ack, busy, overflow, pr_write, pr_init}), 32'd0);
        chk("rst_card_orig", 32'({pr_card, pr_orig}), 32'd0);
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pr_write) begin ok = 1'b1; break; end
        end
        chk("boot_init_write", 32'(ok), 32'd1);
        chk("boot_init_flag", 32'(pr_init), 32'd1);
        chk("boot_no_ack", 32'({p_ack, d_ack}), 32'd0);
        tick();
        chk("boot_busy_wait", 32'(busy), 32'd1);
        wait_idle();

        do_req(0, 6'd13);
        do_req(0, 6'($urandom));

        // random single requests
        for (int n = 0; n < 14; n++) begin
            wlen = $urandom_range(0, 6);
            do_req($urandom_range(0, 1), 6'($urandom));
        end

        // force the player hand past its capacity
        wlen = 2;
        for (int n = 0; n < 9; n++) do_req(0, 6'($urandom));
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // clear empties both hands
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        expect_init_first();
        chk("clr_ovf_cleared", 32'(overflow), 32'd0);
        wait_idle();
        do_req(0, 6'($urandom));

        // both held: round-robin order
        p_req = 1'b1; p_card = 6'($urandom);
        d_req = 1'b1; d_card = 6'($urandom);
        grants = 0;
        for (int i = 0; i < 200 && grants < 4; i++) begin
            tick();
            if (p_ack || d_ack) begin
                side = d_ack ? 1 : 0;
                chk("rr_single_ack", 32'(p_ack & d_ack), 32'd0);
                chk("rr_side", 32'(side), 32'(ptr));
                chk("rr_orig", 32'(pr_orig), 32'(exp_orig(side, side ? dcnt : pcnt)));
                chk("rr_card", 32'(pr_card), 32'(side ? d_card : p_card));
                if (side != 0) begin dcnt++; d_card = 6'($urandom); end
                else           begin pcnt++; p_card = 6'($urandom); end
                ptr = ~ptr;
                grants++;
            end
        end
        p_req = 1'b0; d_req = 1'b0;
        chk("rr_grants", 32'(grants), 32'd4);
        wait_idle();

        // clear during WAIT of a card write, with a dealer request held
        wlen = 5;
        do_req(0, 6'($urandom));
        p_req = 1'b1; p_card = 6'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (p_ack) begin ok = 1'b1; break; end
        end
        chk("clrwait_p_ack", 32'(ok), 32'd1);
        p_req = 1'b0;
        tick();
        tick();
        clr_req = 1'b1;
        d_req = 1'b1;
        c = 6'($urandom);
        d_card = c;
        tick();
        clr_req = 1'b0;
        chk("clrwait_still_busy", 32'(busy), 32'd1);
        expect_init_first();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (d_ack) begin ok = 1'b1; break; end
        end
        chk("clrwait_d_ack", 32'(ok), 32'd1);
        chk("clrwait_d_orig", 32'(pr_orig), 32'(exp_orig(1, 0)));
        chk("clrwait_d_card", 32'(pr_card), 32'(c));
        d_req = 1'b0;
        wait_idle();

        // reset during GUARD
        p_req = 1'b1; p_card = 6'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (p_ack) begin ok = 1'b1; break; end
        end
        chk("guard_p_ack", 32'(ok), 32'd1);
        p_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("guard_rst_outputs", 32'({p_ack, d_ack, busy, overflow, pr_write, pr_init, pr_card, pr_orig}), 32'd0);
        tick();
        rst = 1'b0;
        ptr = 1'b0;
        d_req = 1'b1;
        c = 6'($urandom);
        d_card = c;
        expect_init_first();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (d_ack) begin ok = 1'b1; break; end
        end
        chk("post_rst_d_ack", 32'(ok), 32'd1);
        chk("post_rst_d_orig", 32'(pr_orig), 32'(exp_orig(1, 0)));
        d_req = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
